// File: rtl/osc_clkdiv_multi_if.sv
// Divisor programming bus for osc_clkdiv_multi.
// Carries a one-cycle write strobe with channel and value, and returns a one-cycle acknowledge.
interface osc_clkdiv_multi_if #(
  parameter int CH_W  = 2,
  parameter int DIV_W = 16
);

  logic             div_wr;
  logic [CH_W-1:0]  div_ch;
  logic [DIV_W-1:0] div_val;
  logic             div_ack;

  modport master (
    output div_wr,
    output div_ch,
    output div_val,
    input  div_ack
  );

  modport slave (
    input  div_wr,
    input  div_ch,
    input  div_val,
    output div_ack
  );

endinterface

// File: rtl/osc_clkdiv_multi.sv
// Multi-channel programmable divider on the oscillator clock.
// Each channel emits a one-cycle enable every D cycles plus a square wave; divisor changes land only on period boundaries.
module osc_clkdiv_multi #(
  parameter int NUM_CH         = 4,
  parameter int DIV_W          = 16,
  parameter int DEF_DIV        = 40,
  parameter int STARTUP_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  osc_clkdiv_multi_if.slave  bus,
  output logic               ready,
  output logic [NUM_CH-1:0]  ce,
  output logic [NUM_CH-1:0]  sq
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  typedef enum logic {
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q;

  logic [DIV_W-1:0]  curDiv_q   [NUM_CH];
  logic [DIV_W-1:0]  curDiv_d   [NUM_CH];
  logic [DIV_W-1:0]  pendDiv_q  [NUM_CH];
  logic [DIV_W-1:0]  pendDiv_d  [NUM_CH];
  logic [DIV_W-1:0]  phase_q    [NUM_CH];
  logic [DIV_W-1:0]  phase_d    [NUM_CH];
  logic [NUM_CH-1:0] pendValid_q, pendValid_d;
  logic [NUM_CH-1:0] started_q, started_d;
  logic [NUM_CH-1:0] ce_q, ce_d;
  logic [NUM_CH-1:0] sq_q, sq_d;

  logic              running;
  logic [DIV_W-1:0]  deff;
  logic [DIV_W-1:0]  newDeff;
  logic [DIV_W-1:0]  phaseNext;

  // A programmed divisor of zero behaves as divide-by-one.
  function automatic logic [DIV_W-1:0] effDiv(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  assign running     = (state_q == ST_RUN);
  assign ready       = running;
  assign ce          = ce_q;
  assign sq          = sq_q;
  assign bus.div_ack = ack_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Per-channel phase tracking; a pending divisor is only adopted at the wrap so no period is ever cut short.
  always_comb begin
    pendValid_d = pendValid_q;
    started_d   = started_q;
    ce_d        = '0;
    sq_d        = '0;
    deff        = '0;
    newDeff     = '0;
    phaseNext   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      curDiv_d[i]  = curDiv_q[i];
      pendDiv_d[i] = pendDiv_q[i];
      phase_d[i]   = phase_q[i];
      deff         = effDiv(curDiv_q[i]);
      newDeff      = deff;
      phaseNext    = phase_q[i] + DIV_W'(1);

      if (!running) begin
        curDiv_d[i]    = pendDiv_q[i];
        pendValid_d[i] = 1'b0;
        phase_d[i]     = '0;
        started_d[i]   = 1'b0;
      end else if (phase_q[i] == deff - DIV_W'(1)) begin
        if (pendValid_q[i]) begin
          curDiv_d[i]    = pendDiv_q[i];
          pendValid_d[i] = 1'b0;
          newDeff        = effDiv(pendDiv_q[i]);
        end
        phase_d[i]   = '0;
        started_d[i] = 1'b1;
        ce_d[i]      = 1'b1;
        sq_d[i]      = ((newDeff >> 1) != '0);
      end else begin
        phase_d[i] = phaseNext;
        sq_d[i]    = started_q[i] && (phaseNext < (deff >> 1));
      end

      // A write landing on the wrap cycle stays pending for the following wrap.
      if (bus.div_wr && (bus.div_ch == CH_W'(i))) begin
        pendDiv_d[i]   = bus.div_val;
        pendValid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      pendValid_q <= '0;
      started_q   <= '0;
      ce_q        <= '0;
      sq_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        curDiv_q[i]  <= DIV_W'(DEF_DIV);
        pendDiv_q[i] <= DIV_W'(DEF_DIV);
        phase_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= bus.div_wr;
      pendValid_q <= pendValid_d;
      started_q   <= started_d;
      ce_q        <= ce_d;
      sq_q        <= sq_d;
      for (int i = 0; i < NUM_CH; i++) begin
        curDiv_q[i]  <= curDiv_d[i];
        pendDiv_q[i] <= pendDiv_d[i];
        phase_q[i]   <= phase_d[i];
      end
    end
  end

endmodule
